router_ingress_buffer: RTL and testbench
========================================

# router_ingress_buffer

Sequential ingress stage placed directly upstream of the combinational `top` router netlist. It buffers header flits from two input channels (A, B) in per-channel FIFOs and pairs the channel heads into a stable 60-bit router input vector. It captures the router's 3-bit decision into a registered output handshake, giving the otherwise combinational router a clean, pipelined, back-pressured boundary.

## Interface
Parameters:
- `DEPTH`, 4 — entries per channel FIFO; a power of two, at least 2.
- `HDR_W`, 30 — header width per channel. Fixed by the router: A drives x0..x29, B drives x30..x59.
- `TIMEOUT`, 15 — cycles a lone head waits before being paired with a zero pad. 0 disables padding.

Ports (clock and reset first):
- `clk` in 1 — the single clock.
- `rst` in 1 — asynchronous, active-high reset.
- `a_valid` in 1 — channel A flit valid.
- `a_ready` out 1 — channel A can accept.
- `a_hdr` in HDR_W — channel A header.
- `b_valid` in 1 — channel B flit valid.
- `b_ready` out 1 — channel B can accept.
- `b_hdr` in HDR_W — channel B header.
- `rt_x` out 2*HDR_W — router input; `{b_pair, a_pair}`, bit i drives xi.
- `rt_y` in 3 — router outputs y2..y0.
- `dec_valid` out 1 — decision available.
- `dec_ready` in 1 — consumer accepts the decision.
- `dec_route` out 3 — registered `rt_y`.
- `dec_pad` out 2 — bit0 set: A side padded; bit1 set: B side padded.
- `dec_seq` out 8 — decision sequence number; wraps 255→0.
- `a_count` out clog2(DEPTH)+1 — channel A FIFO occupancy.
- `b_count` out clog2(DEPTH)+1 — channel B FIFO occupancy.

## Operation
- **FIFOs.** `x_ready = (x_count < DEPTH)`. A push occurs on `valid & ready`. A full FIFO refuses a push even if it pops in the same cycle. Push and pop in the same cycle on a non-full FIFO leave the count unchanged.
- **Pair register.** Holds `a_pair`, `b_pair` and the pad flags. `rt_x` is driven only from this register and never from the FIFOs directly.
- **Load condition.** A load is permitted when the FSM is in IDLE, or in HOLD with `dec_valid & dec_ready`.
  - Both FIFOs non-empty: pop both, pad = 00.
  - Exactly one FIFO non-empty and `tmo_cnt == TIMEOUT` (TIMEOUT > 0): pop that FIFO, load zeros on the other side, and set the pad bit for the zeroed side.
- **Timeout counter.**
  - Increments in any cycle where exactly one FIFO is non-empty and no load occurs.
  - Saturates at TIMEOUT.
  - Clears on any load, and whenever both FIFOs or neither FIFO is non-empty.
- **FSM states.**
  - IDLE → EVAL on load.
  - EVAL → HOLD unconditionally. On this edge, `rt_y` is captured into `dec_route`, `dec_valid` is set, and `dec_seq` increments.
  - HOLD, on handshake → EVAL if a load occurs in that cycle, else IDLE (`dec_valid` clears).
  - HOLD without handshake → HOLD. Outputs stay stable, and the pair register and `rt_x` are held.
- `dec_pad` is copied from the pair register on the EVAL → HOLD edge.
- **Width rule.** `dec_seq` is 8-bit modular; occupancy counts are DEPTH-inclusive.

## Timing
- **Reset values (async on `rst`, applies at any time):**
  - FIFOs empty; `a_count` = `b_count` = 0; `a_ready` = `b_ready` = 1 once reset is released.
  - `rt_x` = 0, `dec_valid` = 0, `dec_route` = 0, `dec_pad` = 0, `dec_seq` = 0.
  - FSM = IDLE; `tmo_cnt` = 0.
- **Reset mid-operation** discards all buffered flits and any pending decision.
- **Latency.**
  - Flits accepted on edge 0 on both channels: heads visible in cycle 1, load on edge 1, EVAL during cycle 2, `dec_valid` high from edge 2.
  - Minimum is therefore 2 cycles from accept edge to `dec_valid`.
- **Throughput.** One decision per 2 cycles (EVAL, HOLD) with `dec_ready` held high.
- **Router path.** `rt_y` is sampled exactly one cycle after `rt_x` changes; the router's combinational path must close in one cycle.
- **Lone flit.** A lone flit accepted on edge 0 with the other FIFO empty is loaded on edge TIMEOUT+1.

## Structure
- **Shared package `router_pkg`:** `HDR_W` (30), `ROUTE_W` (3), FSM state enum {IDLE, EVAL, HOLD}, and pad-bit position constants.
- **Sub-module `router_hdr_fifo`:** parameterised by width and depth, with `count` output. Instantiated twice (A and B).
- The FSM, pair register and timeout counter live in the top module.

## Test plan
- **Paired path.** Single A = 0x2000_0001 and B = 0x0000_0001 on the same edge, `dec_ready` = 1. Expect `rt_x` = {B, A} from edge 1, `dec_valid` = 1 two edges after accept, `dec_route` equal to the router output for that `rt_x`, `dec_seq` = 1, `dec_pad` = 00.
- **Timeout pad.** A-only flit with TIMEOUT = 15. Expect no load for 15 cycles, load on edge 16 with B side = 0, `dec_pad` = 10.
- **Back-pressure.** `dec_ready` = 0 for 20 cycles while both channels push continuously. Expect `a_count` = `b_count` = 4, `a_ready` = `b_ready` = 0, and `dec_*` and `rt_x` stable. Release → decisions drain in order with `dec_seq` incrementing by 1.
- **Full FIFO, simultaneous pop.** With the FIFO full, assert `a_valid` during the cycle of a pop. Expect the push to be rejected and `a_count` = 3 after the edge.
- **Reset mid-HOLD.** Assert `rst` while `dec_valid` = 1. Expect all outputs at reset values immediately, and the first post-reset decision to carry `dec_seq` = 1.
- **Sequence wrap.** 256 decisions. Expect `dec_seq` to go 255 → 0 with no stall.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and types for the router ingress stage
package router_pkg;

  localparam int HDR_W   = 30;
  localparam int ROUTE_W = 3;

  // Pad flag bit positions inside the 2-bit pad field
  localparam int PAD_A_BIT = 0;
  localparam int PAD_B_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/router_hdr_fifo.sv
// rtl/router_hdr_fifo.sv - per-channel header FIFO with occupancy count
module router_hdr_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses pushes even when it is popped in the same cycle
  assign push_ready = (count < CW'(DEPTH));
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop & (count != '0);
  assign head       = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/router_ingress_buffer.sv
// rtl/router_ingress_buffer.sv - buffers A/B header flits and registers the router decision
module router_ingress_buffer
  import router_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HDR_W   = router_pkg::HDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [HDR_W-1:0]       a_hdr,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [HDR_W-1:0]       b_hdr,
  output logic [2*HDR_W-1:0]     rt_x,
  input  logic [ROUTE_W-1:0]     rt_y,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [ROUTE_W-1:0]     dec_route,
  output logic [1:0]             dec_pad,
  output logic [7:0]             dec_seq,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  localparam int  TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit  PAD_EN = (TIMEOUT > 0);

  state_t           state;
  logic [HDR_W-1:0] a_head;
  logic [HDR_W-1:0] b_head;
  logic [HDR_W-1:0] a_pair;
  logic [HDR_W-1:0] b_pair;
  logic [1:0]       pad_q;
  logic [1:0]       pad_d;
  logic [TW-1:0]    tmo_cnt;
  logic             a_ne;
  logic             b_ne;
  logic             one_ne;
  logic             load_ok;
  logic             load;

  router_hdr_fifo #(.W(HDR_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst        (rst),
    .push_valid (a_valid),
    .push_ready (a_ready),
    .push_data  (a_hdr),
    .pop        (load & a_ne),
    .head       (a_head),
    .count      (a_count)
  );

  router_hdr_fifo #(.W(HDR_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst        (rst),
    .push_valid (b_valid),
    .push_ready (b_ready),
    .push_data  (b_hdr),
    .pop        (load & b_ne),
    .head       (b_head),
    .count      (b_count)
  );

  assign a_ne    = (a_count != '0);
  assign b_ne    = (b_count != '0);
  assign one_ne  = a_ne ^ b_ne;
  // A new pair may enter only when no decision is outstanding or it is being consumed now
  assign load_ok = (state == IDLE) || ((state == HOLD) && dec_valid && dec_ready);
  assign load    = load_ok && ((a_ne && b_ne) ||
                               (PAD_EN && one_ne && (tmo_cnt == TW'(TIMEOUT))));
  assign rt_x    = {b_pair, a_pair};

  // Pad flags mark whichever side had no head at load time
  always_comb begin
    pad_d            = 2'b00;
    pad_d[PAD_A_BIT] = ~a_ne;
    pad_d[PAD_B_BIT] = ~b_ne;
  end

  // Pair register: the only source of the router input vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_pair <= '0;
      b_pair <= '0;
      pad_q  <= 2'b00;
    end else if (load) begin
      a_pair <= a_ne ? a_head : '0;
      b_pair <= b_ne ? b_head : '0;
      pad_q  <= pad_d;
    end
  end

  // Lone-head wait counter, saturating at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (load || !one_ne) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Decision FSM: EVAL gives the router one cycle, HOLD presents the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dec_valid <= 1'b0;
      dec_route <= '0;
      dec_pad   <= 2'b00;
      dec_seq   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load) state <= EVAL;
        end
        EVAL: begin
          state     <= HOLD;
          dec_valid <= 1'b1;
          dec_route <= rt_y;
          dec_pad   <= pad_q;
          dec_seq   <= dec_seq + 8'd1;
        end
        HOLD: begin
          if (dec_ready) begin
            dec_valid <= 1'b0;
            state     <= load ? EVAL : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ingress_buffer.sv
// tb/tb_router_ingress_buffer.sv - self-checking bench for router_ingress_buffer
module tb_router_ingress_buffer;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [29:0] a_hdr;
  logic        b_valid;
  logic        b_ready;
  logic [29:0] b_hdr;
  logic [59:0] rt_x;
  logic [2:0]  rt_y;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  dec_route;
  logic [1:0]  dec_pad;
  logic [7:0]  dec_seq;
  logic [2:0]  a_count;
  logic [2:0]  b_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [59:0] expq [$];
  logic [7:0]  exp_seq;

  // Stand-in for the combinational router netlist
  function automatic logic [2:0] route_fn(input logic [59:0] x);
    return x[2:0] ^ x[32:30] ^ x[59:57] ^ {2'b00, ^x};
  endfunction

  assign rt_y = route_fn(rt_x);

  router_ingress_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_hdr     (a_hdr),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_hdr     (b_hdr),
    .rt_x      (rt_x),
    .rt_y      (rt_y),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_route (dec_route),
    .dec_pad   (dec_pad),
    .dec_seq   (dec_seq),
    .a_count   (a_count),
    .b_count   (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    dec_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    expq.delete();
    exp_seq = 8'd0;
  endtask

  // A decision is consumed on the coming edge: compare it with the oldest expected pair
  task automatic check_dec();
    logic [59:0] p;
    p = 60'd0;
    if (expq.size() == 0) begin
      chk("dec_unexpected", 64'd1, 64'd0);
    end else begin
      p = expq.pop_front();
      exp_seq = exp_seq + 8'd1;
      chk("dec_rtx", rt_x, p);
      chk("dec_route", dec_route, route_fn(p));
      chk("dec_pad", dec_pad, 2'b00);
      chk("dec_seq", dec_seq, exp_seq);
    end
  endtask

  // Paired random traffic; pairs are pushed only when both sides accept
  task automatic run(input int max_cyc, input int push_pct, input int rdy_pct,
                     input int want, input bit check_gap);
    int got;
    int last;
    got  = 0;
    last = 0;
    for (int c = 0; c < max_cyc && got < want; c++) begin
      dec_ready = ($urandom_range(99) < rdy_pct);
      if (dec_valid && dec_ready) begin
        if (check_gap && got > 0) chk("dec_gap", c - last, 2);
        last = c;
        check_dec();
        got++;
      end
      if (($urandom_range(99) < push_pct) && a_ready && b_ready) begin
        a_hdr   = 30'($urandom);
        b_hdr   = 30'($urandom);
        a_valid = 1'b1;
        b_valid = 1'b1;
        expq.push_back({b_hdr, a_hdr});
      end else begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("decisions_done", got, want);
  endtask

  initial begin
    logic [59:0] snap_x;
    logic [2:0]  snap_route;
    logic [7:0]  snap_seq;
    logic [1:0]  snap_pad;
    logic [29:0] da;
    snap_x = '0; snap_route = '0; snap_seq = '0; snap_pad = '0;
    a_hdr = '0;
    b_hdr = '0;
    do_reset();

    // Reset state
    chk("rst_rtx", rt_x, 60'd0);
    chk("rst_valid", dec_valid, 1'b0);
    chk("rst_route", dec_route, 3'd0);
    chk("rst_pad", dec_pad, 2'b00);
    chk("rst_seq", dec_seq, 8'd0);
    chk("rst_acount", a_count, 3'd0);
    chk("rst_bcount", b_count, 3'd0);
    chk("rst_aready", a_ready, 1'b1);
    chk("rst_bready", b_ready, 1'b1);

    // Paired path latency
    dec_ready = 1'b1;
    a_hdr = 30'h2000_0001; b_hdr = 30'h0000_0001;
    a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("pp_acount_e0", a_count, 3'd1);
    chk("pp_rtx_e0", rt_x, 60'd0);
    tick();
    chk("pp_rtx_e1", rt_x, {30'h0000_0001, 30'h2000_0001});
    chk("pp_valid_e1", dec_valid, 1'b0);
    chk("pp_acount_e1", a_count, 3'd0);
    tick();
    chk("pp_valid_e2", dec_valid, 1'b1);
    chk("pp_route", dec_route, route_fn({30'h0000_0001, 30'h2000_0001}));
    chk("pp_seq", dec_seq, 8'd1);
    chk("pp_pad", dec_pad, 2'b00);
    tick();
    chk("pp_valid_e3", dec_valid, 1'b0);

    // Lone A flit padded after the timeout
    do_reset();
    dec_ready = 1'b1;
    da = 30'h2AAA_AAAA;
    a_hdr = da; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("tmo_wait_acount", a_count, 3'd1);
    end
    chk("tmo_wait_rtx", rt_x, 60'd0);
    tick();
    chk("tmo_load_acount", a_count, 3'd0);
    chk("tmo_load_rtx", rt_x, {30'd0, da});
    tick();
    chk("tmo_valid", dec_valid, 1'b1);
    chk("tmo_pad", dec_pad, 2'b10);
    chk("tmo_route", dec_route, route_fn({30'd0, da}));
    chk("tmo_seq", dec_seq, 8'd1);

    // Back-pressure with continuous pushes
    do_reset();
    dec_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      a_hdr = 30'($urandom); b_hdr = 30'($urandom);
      a_valid = 1'b1; b_valid = 1'b1;
      if (a_ready && b_ready) expq.push_back({b_hdr, a_hdr});
      tick();
      if (i == 3) begin
        snap_x = rt_x; snap_route = dec_route; snap_seq = dec_seq; snap_pad = dec_pad;
        chk("bp_valid_early", dec_valid, 1'b1);
      end
    end
    chk("bp_acount", a_count, 3'd4);
    chk("bp_bcount", b_count, 3'd4);
    chk("bp_aready", a_ready, 1'b0);
    chk("bp_bready", b_ready, 1'b0);
    chk("bp_stable_rtx", rt_x, snap_x);
    chk("bp_stable_route", dec_route, snap_route);
    chk("bp_stable_seq", dec_seq, snap_seq);
    chk("bp_stable_pad", dec_pad, snap_pad);
    chk("bp_valid", dec_valid, 1'b1);

    // Full FIFO popped while A offers a flit: the push must be refused
    a_valid = 1'b1; b_valid = 1'b0;
    dec_ready = 1'b1;
    check_dec();
    tick();
    a_valid = 1'b0;
    chk("full_pop_acount", a_count, 3'd3);
    chk("full_pop_bcount", b_count, 3'd3);
    run(100, 0, 100, expq.size(), 1'b0);

    // Reset while a decision is held
    do_reset();
    dec_ready = 1'b0;
    a_hdr = 30'($urandom); b_hdr = 30'($urandom);
    a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 10 && !dec_valid; i++) tick();
    chk("mid_hold_reached", dec_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rtx", rt_x, 60'd0);
    chk("mid_rst_valid", dec_valid, 1'b0);
    chk("mid_rst_route", dec_route, 3'd0);
    chk("mid_rst_pad", dec_pad, 2'b00);
    chk("mid_rst_seq", dec_seq, 8'd0);
    chk("mid_rst_acount", a_count, 3'd0);
    tick();
    do_reset();
    a_hdr = 30'($urandom); b_hdr = 30'($urandom);
    a_valid = 1'b1; b_valid = 1'b1;
    expq.push_back({b_hdr, a_hdr});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    run(20, 0, 100, 1, 1'b0);

    // Sequence wrap at full throughput
    do_reset();
    run(1200, 100, 100, 256, 1'b1);
    chk("wrap_seq_last", dec_seq, 8'd0);
    run(50, 0, 100, expq.size(), 1'b0);

    // Random traffic and random back-pressure
    do_reset();
    run(3000, 50, 60, 300, 1'b0);
    run(200, 0, 100, expq.size(), 1'b0);
    chk("final_acount", a_count, 3'd0);
    chk("final_bcount", b_count, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
